// File: rtl/receiver_frame_sequencer_if.sv
// Frame-in / word-out handshake bundle for the receiver frame sequencer.
// slave is the sequencer's view; master is the source/sink side.
interface receiver_frame_sequencer_if #(
    parameter int N = 16,
    parameter int M = 6
);
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [M-1:0] m_data;
    logic         m_error;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_error
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_error
    );
endinterface

// File: rtl/receiver_frame_sequencer.sv
// Runs the Hadamard/PAM Receiver one frame at a time: load, reset pulse,
// N run cycles, then hands the decoded word to the sink.
module receiver_frame_sequencer #(
    parameter int HADAMARD      = 4,
    parameter int PAM_LEVEL_LOG = 2,
    parameter int BIT_NUM       = $clog2(HADAMARD) + PAM_LEVEL_LOG,
    parameter int N             = HADAMARD * BIT_NUM,
    parameter int M             = (HADAMARD - 1) * PAM_LEVEL_LOG,
    parameter int CNT_W         = $clog2(N + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    receiver_frame_sequencer_if.slave    bus,
    output logic                         rx_resetn,
    output logic [N-1:0]                 rx_input_data,
    input  logic [M-1:0]                 rx_output_data,
    input  logic                         rx_ready,
    output logic                         busy,
    output logic [15:0]                  frame_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rx_resetn_q, rx_resetn_d;
    logic [N-1:0]       in_q, in_d;
    logic               m_valid_q, m_valid_d;
    logic [M-1:0]       m_data_q, m_data_d;
    logic               m_error_q, m_error_d;
    logic [15:0]        fc_q, fc_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_resetn_d = rx_resetn_q;
        in_d        = in_q;
        m_valid_d   = m_valid_q;
        m_data_d    = m_data_q;
        m_error_d   = m_error_q;
        fc_d        = fc_q;
        unique case (state_q)
            IDLE: begin
                if (bus.s_valid) begin
                    in_d    = bus.s_data;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d       = '0;
                rx_resetn_d = 1'b1;
                state_d     = RUN;
            end
            RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // capture on the edge that brings the count to N
                if (cnt_q == CNT_W'(N - 1)) begin
                    m_data_d    = rx_output_data;
                    m_error_d   = ~rx_ready;
                    m_valid_d   = 1'b1;
                    rx_resetn_d = 1'b0;
                    state_d     = HOLD;
                end
            end
            HOLD: begin
                if (bus.m_ready) begin
                    m_valid_d = 1'b0;
                    fc_d      = fc_q + 16'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_resetn_q <= 1'b0;
            in_q        <= '0;
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_error_q   <= 1'b0;
            fc_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_resetn_q <= rx_resetn_d;
            in_q        <= in_d;
            m_valid_q   <= m_valid_d;
            m_data_q    <= m_data_d;
            m_error_q   <= m_error_d;
            fc_q        <= fc_d;
        end
    end

    assign bus.s_ready   = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign bus.m_valid   = m_valid_q;
    assign bus.m_data    = m_data_q;
    assign bus.m_error   = m_error_q;
    assign rx_resetn     = rx_resetn_q;
    assign rx_input_data = in_q;
    assign frame_count   = fc_q;

endmodule

// File: tb/tb_receiver_frame_sequencer.sv
// Bench for receiver_frame_sequencer: behavioural Receiver stub plus a
// queue-based reference of accepted frames and expected decoded words.
module tb_receiver_frame_sequencer;
    localparam int N = 16;
    localparam int M = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    receiver_frame_sequencer_if #(.N(N), .M(M)) bus ();

    logic          rx_resetn;
    logic [N-1:0]  rx_input_data;
    logic [M-1:0]  rx_output_data;
    logic          rx_ready;
    logic          busy;
    logic [15:0]   frame_count;
    logic          inject = 1'b0;

    receiver_frame_sequencer #(.HADAMARD(4), .PAM_LEVEL_LOG(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .rx_resetn      (rx_resetn),
        .rx_input_data  (rx_input_data),
        .rx_output_data (rx_output_data),
        .rx_ready       (rx_ready),
        .busy           (busy),
        .frame_count    (frame_count)
    );

    function automatic logic [M-1:0] dec(input logic [N-1:0] x);
        if (x == 16'hA5C3) return 6'h2D;
        return x[5:0] ^ x[11:6] ^ {2'b00, x[15:12]};
    endfunction

    // Receiver stub: word is valid only after exactly N-1 completed run clocks,
    // so the sequencer's Nth run edge is the only one that sees it.
    logic [4:0] run_cnt = '0;
    always @(posedge clk) begin
        if (!rx_resetn) run_cnt <= '0;
        else            run_cnt <= run_cnt + 5'd1;
    end
    wire at_cap = (run_cnt == 5'(N - 1));
    assign rx_output_data = at_cap ? dec(rx_input_data) : ~dec(rx_input_data);
    assign rx_ready       = at_cap && !inject;

    typedef struct packed {
        logic [M-1:0] d;
        logic         e;
        logic [N-1:0] src;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          dlv_cnt = 0;
    int          last_acc = 0;
    bit          b2b = 0;
    int          b2b_n = 0;
    logic [15:0] fc_m = '0;
    logic        p_sready = 1'b0;
    logic        p_mvalid = 1'b0;
    logic [M-1:0] p_mdata = '0;
    logic        p_merr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        bit   got;
        bit   empty;
        got   = 0;
        empty = 0;
        e     = '0;
        @(posedge clk);
        cyc++;
        if (reset) begin
            q.delete();
            fc_m = '0;
        end else begin
            if (p_sready && bus.s_valid) begin
                if (b2b) begin
                    if (b2b_n > 0) chk("spacing", cyc - last_acc, N + 3);
                    b2b_n++;
                end
                q.push_back('{d: dec(bus.s_data), e: inject, src: bus.s_data});
                acc_cnt++;
                last_acc = cyc;
            end
            if (p_mvalid && bus.m_ready) begin
                if (q.size() == 0) empty = 1;
                else e = q.pop_front();
                got = 1;
                fc_m++;
                dlv_cnt++;
            end
        end
        #1;
        if (got) begin
            chk("word_expected", {31'd0, empty}, 32'd0);
            if (!empty) begin
                chk("m_data", p_mdata, e.d);
                chk("m_error", p_merr, e.e);
                chk("rx_input_data", rx_input_data, e.src);
            end
            chk("frame_count", frame_count, fc_m);
            chk("m_valid_drop", bus.m_valid, 0);
        end
        if (!reset && bus.m_valid && !p_mvalid)
            chk("latency", cyc - last_acc, N + 1);
        p_sready = bus.s_ready;
        p_mvalid = bus.m_valid;
        p_mdata  = bus.m_data;
        p_merr   = bus.m_error;
    endtask

    task automatic send(input logic [N-1:0] d);
        int n;
        n = acc_cnt;
        bus.s_data  = d;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 60 && acc_cnt == n; i++) step();
        chk("send_timeout", acc_cnt != n, 1);
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_dlv(input int lim);
        int n;
        n = dlv_cnt;
        for (int i = 0; i < lim && dlv_cnt == n; i++) step();
        chk("deliver_timeout", dlv_cnt != n, 1);
    endtask

    task automatic wait_mvalid(input int lim);
        for (int i = 0; i < lim && !bus.m_valid; i++) step();
        chk("mvalid_timeout", bus.m_valid, 1);
    endtask

    initial begin
        logic [M-1:0] held;
        int           base;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;

        // reset state
        reset = 1'b1;
        repeat (3) step();
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_rx_resetn", rx_resetn, 0);
        chk("rst_rx_input", rx_input_data, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_m_error", bus.m_error, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fc", frame_count, 0);
        reset = 1'b0;
        step();

        // single frame
        bus.m_ready = 1'b1;
        send(16'hA5C3);
        chk("t1_busy", busy, 1);
        chk("t1_s_ready", bus.s_ready, 0);
        wait_dlv(40);
        chk("t1_data", p_mdata, 6'h2D);
        chk("t1_fc", frame_count, 1);

        // back-to-back with source and sink always ready
        base  = acc_cnt;
        b2b   = 1;
        b2b_n = 0;
        bus.s_data  = N'($urandom);
        bus.s_valid = 1'b1;
        for (int i = 0; i < 100 * (N + 3) + 60 && dlv_cnt < base + 100; i++) begin
            step();
            if (acc_cnt >= base + 100) bus.s_valid = 1'b0;
            else if (p_sready == 1'b0 && bus.s_data == rx_input_data)
                bus.s_data = N'($urandom);
        end
        bus.s_valid = 1'b0;
        b2b = 0;
        chk("t2_count", dlv_cnt, base + 100);
        chk("t2_fc", frame_count, 101);

        // sink stall in HOLD
        bus.m_ready = 1'b0;
        send(N'($urandom));
        wait_mvalid(40);
        held = bus.m_data;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t3_m_valid", bus.m_valid, 1);
            chk("t3_m_data", bus.m_data, held);
            chk("t3_s_ready", bus.s_ready, 0);
            chk("t3_rx_resetn", rx_resetn, 0);
        end
        bus.m_ready = 1'b1;
        wait_dlv(3);
        chk("t3_fc", frame_count, 102);

        // rx_ready low at the capture edge, then a clean frame
        inject = 1'b1;
        send(N'($urandom));
        wait_dlv(40);
        chk("t4_err", p_merr, 1);
        inject = 1'b0;
        send(N'($urandom));
        wait_dlv(40);
        chk("t4_ok", p_merr, 0);

        // reset at RUN count 8
        send(N'($urandom));
        repeat (9) step();
        chk("t5_busy_pre", busy, 1);
        reset = 1'b1;
        step();
        chk("t5_m_valid", bus.m_valid, 0);
        chk("t5_rx_resetn", rx_resetn, 0);
        chk("t5_fc", frame_count, 0);
        chk("t5_busy", busy, 0);
        chk("t5_s_ready", bus.s_ready, 1);
        reset = 1'b0;
        step();
        send(N'($urandom));
        wait_dlv(40);
        chk("t5_fc_after", frame_count, 1);

        // frame_count wrap
        force dut.fc_q = 16'hFFFF;
        step();
        release dut.fc_q;
        fc_m = 16'hFFFF;
        step();
        chk("t6_preload", frame_count, 16'hFFFF);
        send(N'($urandom));
        wait_dlv(40);
        chk("t6_wrap", frame_count, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
